// File: rtl/iob2axi_rd_ctrl.sv
`default_nettype none
// ============================================================================
// iob2axi_rd_ctrl : splits a read command into 4KB-safe, FIFO-credit-limited
//                   bursts for iob2axi_rd and buffers returned words.
// Revision: 1.0
// ============================================================================
module iob2axi_rd_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WORDS_W    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [WORDS_W-1:0] cmd_words,
  output logic               cmd_ready,
  output logic               done,
  output logic               error,
  output logic               run,
  output logic [7:0]         length,
  input  logic               rd_ready,
  input  logic               rd_error,
  output logic               s_valid,
  output logic [ADDR_W-1:0]  s_addr,
  input  logic [DATA_W-1:0]  s_rdata,
  input  logic               s_ready,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_data,
  input  logic               o_ready
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CW     = (WORDS_W > 13) ? WORDS_W : 13;

  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(BYTES - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CALC  = 3'd1;
  localparam logic [2:0] c_REQ   = 3'd2;
  localparam logic [2:0] c_BURST = 3'd3;
  localparam logic [2:0] c_FIN   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORDS_W-1:0] rem_q, rem_d;
  logic [8:0]         burst_q, burst_d;
  logic [8:0]         outst_q, outst_d;
  logic [7:0]         len_q, len_d;
  logic               err_q, err_d;

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     cnt_q;

  logic               w_push, w_pop;
  logic [9:0]         w_credits;
  logic [12:0]        w_bnd_bytes;
  logic [CW-1:0]      w_bnd;
  logic [CW-1:0]      w_lim;

  assign w_push      = (state_q == c_BURST) && s_ready;
  assign w_pop       = o_valid && o_ready;
  assign w_credits   = 10'(FIFO_DEPTH) - 10'(cnt_q) - 10'(outst_q);
  assign w_bnd_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
  assign w_bnd       = CW'(w_bnd_bytes >> BSHIFT);

  // Burst size: smallest of words left, AXI max, distance to 4KB page end, FIFO credits.
  always_comb begin
    w_lim = CW'(256);
    if (CW'(w_credits) < w_lim) w_lim = CW'(w_credits);
    if (w_bnd < w_lim)          w_lim = w_bnd;
    if (CW'(rem_q) < w_lim)     w_lim = CW'(rem_q);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    burst_d = burst_q;
    outst_d = outst_q;
    len_d   = len_q;
    err_d   = err_q;
    if (w_push) outst_d = outst_q - 9'd1;
    case (state_q)
      c_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr & c_ALIGN_MASK;
          rem_d   = cmd_words;
          err_d   = 1'b0;
          state_d = (cmd_words == '0) ? c_FIN : c_CALC;
        end
      end
      c_CALC: begin
        if (w_credits != 10'd0) begin
          burst_d = w_lim[8:0];
          outst_d = w_lim[8:0];
          len_d   = w_lim[7:0] - 8'd1;
          state_d = c_REQ;
        end
      end
      c_REQ: begin
        if (!rd_ready) state_d = c_BURST;
      end
      c_BURST: begin
        if ((outst_q == 9'd0) && rd_ready) begin
          err_d   = err_q | rd_error;
          addr_d  = addr_q + (ADDR_W'(burst_q) << BSHIFT);
          rem_d   = rem_q - WORDS_W'(burst_q);
          state_d = (rem_q == WORDS_W'(burst_q)) ? c_FIN : c_CALC;
        end
      end
      c_FIN:   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      burst_q <= '0;
      outst_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      burst_q <= burst_d;
      outst_q <= outst_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // Output FIFO: first-word fall-through; storage itself needs no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= s_rdata;
  end

  assign cmd_ready = (state_q == c_IDLE);
  assign done      = (state_q == c_FIN);
  assign run       = (state_q == c_REQ);
  assign s_valid   = (state_q == c_BURST);
  assign length    = len_q;
  assign s_addr    = addr_q;
  assign error     = err_q;
  assign o_valid   = (cnt_q != '0);
  assign o_data    = mem_q[rd_ptr_q];

endmodule
`default_nettype wire
